div_unit: RTL

- Multi-cycle 32-bit integer divider for DIV/DIVU, in the EX stage next to the ALU.
- Produces {HI,LO} = {remainder, quotient} in the same 64-bit packing the EX/MEM register carries for multiply results, so HI/LO writeback and forwarding are unchanged.
- Raises busy so the hazard logic stalls IF/ID/EX while a divide is in flight.
- Radix-2 restoring algorithm on magnitudes, with a final sign-fix cycle.

---
 rtl/div_unit_if.sv | 28 ++
 rtl/div_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Handshake bundle between the EX stage and the
// multi-cycle divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               flush;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, is_signed,
    output dividend, divisor, flush,
    input  busy, done, hi, lo, result
  );

  modport slave (
    input  start, is_signed,
    input  dividend, divisor, flush,
    output busy, done, hi, lo, result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU for the EX stage.
// Result packs {hi,lo} = {remainder,quotient}.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dmag_q;
  logic [WIDTH-1:0] raw_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             neg_a_q;
  logic             neg_b_q;
  logic             divzero_q;
  logic             busy_q;
  logic             done_q;

  logic             launch;
  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign launch = bus.start && !bus.flush;
  assign last   = cnt_q == CW'(WIDTH - 1);

  assign a_neg = bus.is_signed
               && bus.dividend[WIDTH-1];
  assign b_neg = bus.is_signed
               && bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? -bus.dividend
                       : bus.dividend;
  assign b_mag = b_neg ? -bus.divisor
                       : bus.divisor;

  // quo_q doubles as the dividend shift register
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dmag_q};

  assign q_fix = (neg_a_q ^ neg_b_q) ? -quo_q
                                     : quo_q;
  assign r_fix = neg_a_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (launch) state_d = CALC;
      CALC: begin
        if (bus.flush)  state_d = IDLE;
        else if (last)  state_d = FIX;
      end
      FIX:  state_d = bus.flush ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == CALC)
              || (state_d == FIX);
      done_q  <= state_d == DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dmag_q    <= '0;
      raw_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= a_mag;
            dmag_q    <= b_mag;
            raw_q     <= bus.dividend;
            neg_a_q   <= a_neg;
            neg_b_q   <= b_neg;
            divzero_q <= bus.divisor == '0;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
          end else begin
            rem_q <= rem_sh[WIDTH-1:0];
          end
          quo_q <= {quo_q[WIDTH-2:0],
                    ~trial[WIDTH]};
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          if (!bus.flush) begin
            if (divzero_q) begin
              lo_q <= '1;
              hi_q <= raw_q;
            end else begin
              lo_q <= q_fix;
              hi_q <= r_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.result = {hi_q, lo_q};
endmodule
